// File: rtl/cu_vertex_read_coalesce_module.sv
// Read-command coalescer for the vertex cache path: remembers the last DEPTH issued
// cachelines and turns repeat requests into reuse events instead of memory reads.
module cu_vertex_read_coalesce_module #(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned TAG_WIDTH       = 8,
    parameter int unsigned CACHELINE_BYTES = 128,
    parameter int unsigned DEPTH           = 8
) (
    input  logic                       clock,
    input  logic                       rst_in,
    input  logic                       enabled_in,
    input  logic                       flush_in,
    input  logic                       cmd_in_valid,
    input  logic [ADDR_WIDTH-1:0]      cmd_in_addr,
    input  logic [TAG_WIDTH-1:0]       cmd_in_tag,
    output logic                       cmd_in_ready,
    output logic                       cmd_out_valid,
    output logic [ADDR_WIDTH-1:0]      cmd_out_addr,
    output logic [TAG_WIDTH-1:0]       cmd_out_tag,
    input  logic                       cmd_out_ready,
    output logic                       reuse_valid,
    output logic [TAG_WIDTH-1:0]       reuse_tag,
    output logic [$clog2(DEPTH)-1:0]   reuse_index,
    output logic [31:0]                cmd_count,
    output logic [31:0]                reuse_count
);

    localparam int unsigned LINE_SHIFT  = $clog2(CACHELINE_BYTES);
    localparam int unsigned LINE_WIDTH  = ADDR_WIDTH - LINE_SHIFT;
    localparam int unsigned INDEX_WIDTH = $clog2(DEPTH);

    logic [DEPTH-1:0]       entry_valid_q;
    logic [LINE_WIDTH-1:0]  entry_line_q [DEPTH];
    logic [INDEX_WIDTH-1:0] wr_ptr_q;

    logic                   out_valid_q;
    logic [LINE_WIDTH-1:0]  out_line_q;
    logic [TAG_WIDTH-1:0]   out_tag_q;
    logic                   reuse_valid_q;
    logic [TAG_WIDTH-1:0]   reuse_tag_q;
    logic [INDEX_WIDTH-1:0] reuse_index_q;
    logic [31:0]            cmd_count_q;
    logic [31:0]            reuse_count_q;

    logic [LINE_WIDTH-1:0]  req_line;
    logic                   accept;
    logic                   hit;
    logic [INDEX_WIDTH-1:0] hit_index;

    assign req_line     = cmd_in_addr[ADDR_WIDTH-1:LINE_SHIFT];
    assign cmd_in_ready = !rst_in && enabled_in && !flush_in && (!out_valid_q || cmd_out_ready);
    assign accept       = cmd_in_valid && cmd_in_ready;

    // Scan from the top so the lowest matching index wins.
    always_comb begin
        hit       = 1'b0;
        hit_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_valid_q[i] && (entry_line_q[i] == req_line)) begin
                hit       = 1'b1;
                hit_index = i[INDEX_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst_in) begin
            entry_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_line_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_line_q    <= '0;
            out_tag_q     <= '0;
            reuse_valid_q <= 1'b0;
            reuse_tag_q   <= '0;
            reuse_index_q <= '0;
            cmd_count_q   <= '0;
            reuse_count_q <= '0;
        end else begin
            reuse_valid_q <= accept && hit;
            if (accept && hit) begin
                reuse_tag_q   <= cmd_in_tag;
                reuse_index_q <= hit_index;
                reuse_count_q <= reuse_count_q + 32'd1;
            end

            if (accept && !hit) begin
                out_valid_q              <= 1'b1;
                out_line_q               <= req_line;
                out_tag_q                <= cmd_in_tag;
                entry_valid_q[wr_ptr_q]  <= 1'b1;
                entry_line_q[wr_ptr_q]   <= req_line;
                wr_ptr_q                 <= wr_ptr_q + INDEX_WIDTH'(1);
                cmd_count_q              <= cmd_count_q + 32'd1;
            end else if (out_valid_q && cmd_out_ready) begin
                out_valid_q <= 1'b0;
                out_line_q  <= '0;
                out_tag_q   <= '0;
            end

            // Flush never coincides with an accept, so it cannot race an install.
            if (flush_in) begin
                entry_valid_q <= '0;
                wr_ptr_q      <= '0;
            end
        end
    end

    assign cmd_out_valid = out_valid_q;
    assign cmd_out_addr  = {out_line_q, {LINE_SHIFT{1'b0}}};
    assign cmd_out_tag   = out_tag_q;
    assign reuse_valid   = reuse_valid_q;
    assign reuse_tag     = reuse_tag_q;
    assign reuse_index   = reuse_index_q;
    assign cmd_count     = cmd_count_q;
    assign reuse_count   = reuse_count_q;

endmodule

// File: tb/tb_cu_vertex_read_coalesce_module.sv
// Bench for cu_vertex_read_coalesce_module: directed scenarios plus random traffic, all
// checked every cycle against an install-history model of the line table.
module tb_cu_vertex_read_coalesce_module;

    localparam int unsigned AW    = 64;
    localparam int unsigned TW    = 8;
    localparam int unsigned SHIFT = 7;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = AW - SHIFT;

    logic          clock = 1'b0;
    logic          rst_in = 1'b1;
    logic          enabled_in = 1'b0;
    logic          flush_in = 1'b0;
    logic          cmd_in_valid = 1'b0;
    logic [AW-1:0] cmd_in_addr = '0;
    logic [TW-1:0] cmd_in_tag = '0;
    logic          cmd_in_ready;
    logic          cmd_out_valid;
    logic [AW-1:0] cmd_out_addr;
    logic [TW-1:0] cmd_out_tag;
    logic          cmd_out_ready = 1'b0;
    logic          reuse_valid;
    logic [TW-1:0] reuse_tag;
    logic [2:0]    reuse_index;
    logic [31:0]   cmd_count;
    logic [31:0]   reuse_count;

    cu_vertex_read_coalesce_module #(
        .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .CACHELINE_BYTES(128), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .rst_in(rst_in), .enabled_in(enabled_in), .flush_in(flush_in),
        .cmd_in_valid(cmd_in_valid), .cmd_in_addr(cmd_in_addr), .cmd_in_tag(cmd_in_tag),
        .cmd_in_ready(cmd_in_ready), .cmd_out_valid(cmd_out_valid),
        .cmd_out_addr(cmd_out_addr), .cmd_out_tag(cmd_out_tag),
        .cmd_out_ready(cmd_out_ready), .reuse_valid(reuse_valid), .reuse_tag(reuse_tag),
        .reuse_index(reuse_index), .cmd_count(cmd_count), .reuse_count(reuse_count)
    );

    always #5 clock = ~clock;

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: lines installed since the last flush/reset, oldest first; the k-th install
    // (counting from 0) lands in slot k mod DEPTH, so only the last DEPTH are remembered.
    logic [LW-1:0] hist[$];
    int            install_total;
    logic          exp_out_valid;
    logic [AW-1:0] exp_out_addr;
    logic [TW-1:0] exp_out_tag;
    logic          exp_reuse_valid;
    logic [TW-1:0] exp_reuse_tag;
    int            exp_reuse_index;
    logic [31:0]   exp_cmd_count;
    logic [31:0]   exp_reuse_count;

    task automatic model_reset();
        hist.delete();
        install_total   = 0;
        exp_out_valid   = 1'b0;
        exp_out_addr    = '0;
        exp_out_tag     = '0;
        exp_reuse_valid = 1'b0;
        exp_reuse_tag   = '0;
        exp_reuse_index = 0;
        exp_cmd_count   = '0;
        exp_reuse_count = '0;
    endtask

    task automatic model_lookup(input logic [LW-1:0] line, output logic hit, output int slot);
        int base;
        hit  = 1'b0;
        slot = DEPTH;
        base = install_total - hist.size();
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k] == line && ((base + k) % DEPTH) < slot) begin
                hit  = 1'b1;
                slot = (base + k) % DEPTH;
            end
        end
    endtask

    task automatic check_outputs(input logic full);
        check_eq("out_valid", cmd_out_valid, exp_out_valid);
        check_eq("out_addr", cmd_out_addr, exp_out_addr);
        check_eq("out_tag", cmd_out_tag, exp_out_tag);
        check_eq("reuse_valid", reuse_valid, exp_reuse_valid);
        if (exp_reuse_valid || full) begin
            check_eq("reuse_tag", reuse_tag, exp_reuse_tag);
            check_eq("reuse_index", reuse_index, exp_reuse_index);
        end
        check_eq("cmd_count", cmd_count, exp_cmd_count);
        check_eq("reuse_count", reuse_count, exp_reuse_count);
    endtask

    // One clock: drive on the falling edge, check ready, advance the model, check outputs.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic [TW-1:0] t,
                        input logic ordy, input logic en, input logic fl);
        logic          exp_ready;
        logic          acc;
        logic          hit;
        int            slot;
        logic [LW-1:0] line;
        @(negedge clock);
        rst_in        = 1'b0;
        cmd_in_valid  = v;
        cmd_in_addr   = a;
        cmd_in_tag    = t;
        cmd_out_ready = ordy;
        enabled_in    = en;
        flush_in      = fl;
        #1;
        exp_ready = en && !fl && (!exp_out_valid || ordy);
        check_eq("in_ready", cmd_in_ready, exp_ready);
        acc  = v && exp_ready;
        line = a[AW-1:SHIFT];
        model_lookup(line, hit, slot);
        exp_reuse_valid = acc && hit;
        if (acc && hit) begin
            exp_reuse_tag   = t;
            exp_reuse_index = slot;
            exp_reuse_count = exp_reuse_count + 1;
        end
        if (acc && !hit) begin
            exp_out_valid = 1'b1;
            exp_out_addr  = {line, 7'b0};
            exp_out_tag   = t;
            hist.push_back(line);
            install_total++;
            if (hist.size() > DEPTH) void'(hist.pop_front());
            exp_cmd_count = exp_cmd_count + 1;
        end else if (exp_out_valid && ordy) begin
            exp_out_valid = 1'b0;
            exp_out_addr  = '0;
            exp_out_tag   = '0;
        end
        if (fl) begin
            hist.delete();
            install_total = 0;
        end
        @(posedge clock);
        #1;
        check_outputs(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst_in        = 1'b1;
        enabled_in    = 1'b1;
        cmd_in_valid  = 1'b1;
        cmd_in_addr   = {32'h0, $urandom};
        cmd_out_ready = 1'b1;
        #1;
        check_eq("ready_in_reset", cmd_in_ready, 1'b0);
        @(posedge clock);
        #1;
        model_reset();
        check_outputs(1'b1);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = 64'h0000_0042_0000_0000 + 64'($urandom_range(0, 11)) * 128 +
            64'($urandom_range(0, 127));
        return a;
    endfunction

    task automatic random_run(input int cycles, input int ordy_pct);
        for (int i = 0; i < cycles; i++) begin
            step($urandom_range(0, 9) < 7, rand_addr(), TW'($urandom),
                 $urandom_range(0, 99) < ordy_pct, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 29) == 0);
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single miss, then confirm the line sits in entry 0.
        step(1, 64'h1000_0040, 8'd3, 1, 1, 0);
        check_eq("miss_addr", cmd_out_addr, 64'h1000_0000);
        check_eq("miss_tag", cmd_out_tag, 8'd3);
        check_eq("miss_count", cmd_count, 32'd1);
        step(1, 64'h1000_0010, 8'd4, 1, 1, 0);
        check_eq("entry0_hit", reuse_valid, 1'b1);
        check_eq("entry0_idx", reuse_index, 3'd0);

        // Back-to-back same line: command then reuse.
        do_reset();
        step(1, 64'h1000_0000, 8'd1, 1, 1, 0);
        check_eq("b2b_tag", cmd_out_tag, 8'd1);
        step(1, 64'h1000_0078, 8'd2, 1, 1, 0);
        check_eq("b2b_reuse", reuse_valid, 1'b1);
        check_eq("b2b_rtag", reuse_tag, 8'd2);
        check_eq("b2b_cmds", cmd_count, 32'd1);
        check_eq("b2b_reuses", reuse_count, 32'd1);

        // FIFO wrap: nine lines evict line 0 and leave the pointer at 1.
        do_reset();
        for (int k = 0; k < 9; k++) step(1, 64'(k * 128), 8'(k), 1, 1, 0);
        check_eq("wrap_cmds", cmd_count, 32'd9);
        step(1, 64'd128, 8'd19, 1, 1, 0);
        check_eq("wrap_hit1", reuse_valid, 1'b1);
        check_eq("wrap_idx1", reuse_index, 3'd1);
        step(1, 64'd0, 8'd20, 1, 1, 0);
        check_eq("wrap_miss0", cmd_out_valid, 1'b1);
        check_eq("wrap_tag0", cmd_out_tag, 8'd20);

        // Backpressure holds the pending command and stalls input.
        do_reset();
        step(1, 64'h2000, 8'd5, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 64'h3000, 8'd6, 0, 1, 0);
            check_eq("bp_hold_addr", cmd_out_addr, 64'h2000);
            check_eq("bp_stall", cmd_in_ready, 1'b0);
        end
        step(1, 64'h3000, 8'd6, 1, 1, 0);
        check_eq("bp_release_addr", cmd_out_addr, 64'h3000);
        check_eq("bp_release_tag", cmd_out_tag, 8'd6);

        // Flush drops the request in its cycle and empties the table.
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 64'h4000_0000 + 64'(k * 128), 8'(k), 1, 1, 0);
        step(1, 64'h4000_0180, 8'd9, 1, 1, 1);
        check_eq("flush_noacc", cmd_count, 32'd3);
        step(1, 64'h4000_0000, 8'd10, 1, 1, 0);
        check_eq("flush_remiss", cmd_count, 32'd4);
        step(1, 64'h4000_0000, 8'd11, 1, 1, 0);
        check_eq("flush_idx0", reuse_index, 3'd0);
        check_eq("flush_hit", reuse_valid, 1'b1);

        // Random traffic, a reset in the middle of it, then more traffic.
        do_reset();
        random_run(1500, 75);
        random_run(20, 40);
        do_reset();
        step(1, 64'h0000_0042_0000_0000, 8'd7, 1, 1, 0);
        check_eq("post_reset_miss", cmd_out_valid, 1'b1);
        random_run(1500, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/cu_vertex_read_coalesce_module.md
# cu_vertex_read_coalesce_module

Upstream filter for the PageRank CSR PULL vertex cache path. It takes vertex read commands from the compute unit and remembers the last DEPTH cacheline addresses it sent to memory. A repeat request to a remembered line is not sent again; it is reported as a reuse event carrying its tag and entry index. Only new-line commands go on to the read command buffer.

## Interface
Parameters:
- ADDR_WIDTH, 64, byte address width of read commands
- TAG_WIDTH, 8, command tag width
- CACHELINE_BYTES, 128, line size; power of two; line address = addr >> log2(CACHELINE_BYTES)
- DEPTH, 8, number of remembered lines; power of two, ≥2

Ports:
- clock  in  1  single clock; all logic on rising edge
- rst_in  in  1  reset, synchronous, active-high
- enabled_in  in  1  when low, no new command is accepted; state is held
- flush_in  in  1  one-cycle pulse; invalidates all entries
- cmd_in_valid  in  1  request valid
- cmd_in_addr  in  ADDR_WIDTH  request byte address
- cmd_in_tag  in  TAG_WIDTH  request tag
- cmd_in_ready  out  1  request accepted when cmd_in_valid && cmd_in_ready
- cmd_out_valid  out  1  command to the read command buffer
- cmd_out_addr  out  ADDR_WIDTH  address, cacheline-aligned (low bits zero)
- cmd_out_tag  out  TAG_WIDTH  tag of the missing request
- cmd_out_ready  in  1  downstream buffer not full
- reuse_valid  out  1  one-cycle pulse; the request hit a remembered line
- reuse_tag  out  TAG_WIDTH  tag of the hitting request
- reuse_index  out  log2(DEPTH)  index of the matching entry
- cmd_count  out  32  commands issued; wraps
- reuse_count  out  32  reuse events; wraps

## Operation
- Table: DEPTH entries, each {valid, line[ADDR_WIDTH-log2(CACHELINE_BYTES)-1:0]}. A replacement pointer wr_ptr selects the next entry to overwrite.
- Acceptance: cmd_in_ready = enabled_in && !flush_in && (!cmd_out_valid || cmd_out_ready).
- Lookup: on an accepted request, the request line is compared against every valid entry using table contents as of the start of the cycle.
- Hit:
  - Next cycle, reuse_valid = 1, reuse_tag = cmd_in_tag, reuse_index = lowest matching index.
  - cmd_out is not asserted for this request.
  - The table and wr_ptr are unchanged.
  - reuse_count increments.
- Miss:
  - Next cycle, cmd_out_valid = 1, cmd_out_addr = line << log2(CACHELINE_BYTES), cmd_out_tag = cmd_in_tag.
  - Entry[wr_ptr] is set to {1, line}.
  - wr_ptr increments, wrapping from DEPTH-1 to 0 (FIFO replacement).
  - cmd_count increments.
- Output hold: cmd_out_* stay stable while cmd_out_valid && !cmd_out_ready. They clear when the command is taken and no new miss is accepted in the same cycle.
- Flush:
  - All valid bits clear at the next edge and wr_ptr returns to 0.
  - No request is accepted in the flush cycle.
  - A pending cmd_out is kept until downstream takes it.
  - Counters are not cleared.
- Disable: when enabled_in = 0, cmd_in_ready = 0. Any pending cmd_out still drains. Table and counters are held.
- Reset: all outputs and state return to their reset values (see Timing), regardless of any request in flight.

## Timing
- Latency: exactly 1 cycle from acceptance to cmd_out_valid or reuse_valid.
- Throughput: one request per cycle when cmd_out_ready = 1.
- Back-to-back requests:
  - A miss installed in cycle N is visible to the lookup in cycle N+1.
  - Two consecutive requests to the same line therefore produce one command, then one reuse event.
- Stall: cmd_out_ready = 0 with cmd_out_valid = 1 drops cmd_in_ready in the same cycle (combinational).
- Reset values: cmd_in_ready = 0, cmd_out_valid = 0, cmd_out_addr = 0, cmd_out_tag = 0, reuse_valid = 0, reuse_tag = 0, reuse_index = 0, cmd_count = 0, reuse_count = 0. All entries invalid; wr_ptr = 0.
- Counter wrap: 0xFFFF_FFFF + 1 = 0; no saturation.
- reuse_valid is never asserted for more than one cycle per request. It is not subject to cmd_out_ready.

## Test plan
- Single miss: reset, then send addr 0x1000_0040, tag 3 → one cycle later cmd_out_addr = 0x1000_0000, tag 3; cmd_count = 1; entry 0 is valid.
- Reuse: send 0x1000_0000 then 0x1000_0078 on consecutive cycles (tags 1, 2) → one command (tag 1), then reuse_valid with tag 2, index 0; counters cmd = 1, reuse = 1.
- Wrap/eviction (DEPTH = 8): send lines 0..8 (addresses k*128) → 9 commands, wr_ptr = 1. A following request to line 0 misses; a request to line 1 hits with index 1.
- Backpressure: hold cmd_out_ready = 0 for 5 cycles while a miss is pending → cmd_out stays stable, cmd_in_ready = 0. Release → the command is taken and acceptance resumes the same cycle.
- Flush: fill 3 lines, pulse flush_in with cmd_in_valid high → request not accepted that cycle. A re-send of line 0 then misses and installs at index 0.
- Reset mid-stream: assert rst_in while cmd_out_valid = 1 and reuse traffic is active → next cycle all outputs are at reset values and the table is empty.
